// File: rtl/mac_kbd_responder.sv
// mac_kbd_responder: keyboard end of the Mac Plus keyboard link.
// Answers each host command byte with one response byte after a timed
// delay, sourcing key transitions from an internal FIFO.
module mac_kbd_responder #(
    parameter int         FIFO_DEPTH  = 8,
    parameter int         INQ_TIMEOUT = 2000000,
    parameter int         RSP_DELAY   = 16,
    parameter logic [7:0] MODEL_ID    = 8'h0B
) (
    input  logic       clk,
    input  logic       _systemReset,
    input  logic       cep,
    input  logic [7:0] cmd_data,
    input  logic       cmd_strobe,
    input  logic [7:0] key_code,
    input  logic       key_valid,
    output logic       key_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_strobe,
    output logic       overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = $clog2(INQ_TIMEOUT + 1);
    localparam int DW = (RSP_DELAY > 1) ? $clog2(RSP_DELAY + 1) : 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] INQ_LAST = TW'(INQ_TIMEOUT - 1);
    localparam logic [DW-1:0] DLY_LAST = DW'(RSP_DELAY - 1);

    localparam logic [7:0] CMD_INQUIRY = 8'h10;
    localparam logic [7:0] CMD_INSTANT = 8'h14;
    localparam logic [7:0] CMD_MODEL   = 8'h16;
    localparam logic [7:0] CMD_TEST    = 8'h36;
    localparam logic [7:0] RSP_NULL    = 8'h7B;
    localparam logic [7:0] RSP_ACK     = 8'h7D;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_INQ_WAIT = 2'd1,
        ST_RESPOND  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    // key-transition FIFO storage and bookkeeping
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    // timers and response bytes
    logic [TW-1:0] r_inq_tmr;
    logic [DW-1:0] r_dly;
    logic [7:0]    r_latch;
    logic [7:0]    r_rsp_hold;

    // FSM control outputs
    logic          w_pop;
    logic          w_load;
    logic [7:0]    w_load_val;
    logic          w_strobe;
    logic          w_inq_clr;
    logic          w_inq_inc;
    logic          w_dly_inc;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_cmd_known;
    logic [7:0]    w_head;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == FULL_CNT);
    assign w_push      = key_valid && !w_full;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_cmd_known = cmd_strobe &&
                         ((cmd_data == CMD_INQUIRY) || (cmd_data == CMD_INSTANT) ||
                          (cmd_data == CMD_MODEL)   || (cmd_data == CMD_TEST));

    assign key_ready  = !w_full;
    assign overflow   = r_overflow;
    assign rsp_strobe = w_strobe;
    // The strobe cycle presents the freshly delivered byte; otherwise the
    // last delivered byte is held.
    assign rsp_data   = w_strobe ? r_latch : r_rsp_hold;

    // State register
    always_ff @(posedge clk or negedge _systemReset) begin
        if (!_systemReset) r_state <= ST_IDLE;
        else               r_state <= w_next;
    end

    // Next-state and control: a recognised command always wins and restarts
    // decoding, discarding whatever response was pending.
    always_comb begin
        w_next     = r_state;
        w_pop      = 1'b0;
        w_load     = 1'b0;
        w_load_val = 8'h00;
        w_strobe   = 1'b0;
        w_inq_clr  = 1'b0;
        w_inq_inc  = 1'b0;
        w_dly_inc  = 1'b0;
        if (w_cmd_known) begin
            case (cmd_data)
                CMD_INQUIRY: begin
                    w_next    = ST_INQ_WAIT;
                    w_inq_clr = 1'b1;
                end
                CMD_INSTANT: begin
                    w_next = ST_RESPOND;
                    w_load = 1'b1;
                    if (!w_empty) begin
                        w_load_val = w_head;
                        w_pop      = 1'b1;
                    end else begin
                        w_load_val = RSP_NULL;
                    end
                end
                CMD_MODEL: begin
                    w_next     = ST_RESPOND;
                    w_load     = 1'b1;
                    w_load_val = MODEL_ID;
                end
                CMD_TEST: begin
                    w_next     = ST_RESPOND;
                    w_load     = 1'b1;
                    w_load_val = RSP_ACK;
                end
                default: ;
            endcase
        end else begin
            case (r_state)
                ST_INQ_WAIT: begin
                    if (cep) begin
                        if (!w_empty) begin
                            w_next     = ST_RESPOND;
                            w_load     = 1'b1;
                            w_load_val = w_head;
                            w_pop      = 1'b1;
                        end else if (r_inq_tmr == INQ_LAST) begin
                            w_next     = ST_RESPOND;
                            w_load     = 1'b1;
                            w_load_val = RSP_NULL;
                        end else begin
                            w_inq_inc = 1'b1;
                        end
                    end
                end
                ST_RESPOND: begin
                    if (cep) begin
                        if (r_dly == DLY_LAST) begin
                            w_strobe = 1'b1;
                            w_next   = ST_IDLE;
                        end else begin
                            w_dly_inc = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // FIFO storage write; contents need no reset since count gates reads
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= key_code;
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge _systemReset) begin
        if (!_systemReset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (key_valid && w_full) r_overflow <= 1'b1;
        end
    end

    // Inquiry wait timer and response delay counter, both in cep ticks
    always_ff @(posedge clk or negedge _systemReset) begin
        if (!_systemReset) begin
            r_inq_tmr <= '0;
            r_dly     <= '0;
        end else begin
            if (w_inq_clr)      r_inq_tmr <= '0;
            else if (w_inq_inc) r_inq_tmr <= r_inq_tmr + TW'(1);
            if (w_load)         r_dly <= '0;
            else if (w_dly_inc) r_dly <= r_dly + DW'(1);
        end
    end

    // Pending response byte and the last delivered byte
    always_ff @(posedge clk or negedge _systemReset) begin
        if (!_systemReset) begin
            r_latch    <= 8'h00;
            r_rsp_hold <= 8'h00;
        end else begin
            if (w_load)   r_latch    <= w_load_val;
            if (w_strobe) r_rsp_hold <= r_latch;
        end
    end

endmodule

// File: tb/tb_mac_kbd_responder.sv
// Directed bench for mac_kbd_responder (INQ_TIMEOUT shortened to 100).
module tb_mac_kbd_responder;

    logic       clk = 1'b0;
    logic       _systemReset = 1'b0;
    logic       cep = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_strobe = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       key_valid = 1'b0;
    logic       key_ready;
    logic [7:0] rsp_data;
    logic       rsp_strobe;
    logic       overflow;

    int chk_cnt = 0;
    int pass_cnt = 0;
    int strobe_total = 0;
    int bad_strobe = 0;

    mac_kbd_responder #(
        .FIFO_DEPTH (8),
        .INQ_TIMEOUT(100),
        .RSP_DELAY  (16),
        .MODEL_ID   (8'h0B)
    ) dut (
        .clk         (clk),
        ._systemReset(_systemReset),
        .cep         (cep),
        .cmd_data    (cmd_data),
        .cmd_strobe  (cmd_strobe),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .rsp_data    (rsp_data),
        .rsp_strobe  (rsp_strobe),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // cep: one clk in four, changed just after the rising edge
    initial begin
        int n = 0;
        forever begin
            @(posedge clk);
            #1;
            n = n + 1;
            cep = ((n % 4) == 0);
        end
    end

    // strobe monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rsp_strobe) begin
            strobe_total <= strobe_total + 1;
            if (!cep) bad_strobe <= bad_strobe + 1;
        end
    end

    task automatic send_cmd(input logic [7:0] c);
        @(posedge clk); #1;
        cmd_data = c; cmd_strobe = 1'b1;
        @(posedge clk); #1;
        cmd_strobe = 1'b0;
    endtask

    task automatic push_key(input logic [7:0] k);
        @(posedge clk); #1;
        key_code = k; key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    // Counts cep ticks after the command cycle up to and including the strobe.
    task automatic wait_rsp(input int max_cyc, output bit got, output logic [7:0] d, output int n);
        got = 1'b0; d = 8'h00; n = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (cep) n = n + 1;
            if (rsp_strobe) begin
                got = 1'b1; d = rsp_data;
                return;
            end
        end
    endtask

    task automatic expect_rsp(input string name, input logic [7:0] want_d, input int want_n);
        bit got; logic [7:0] d; int n;
        wait_rsp(700, got, d, n);
        chk_cnt++;
        if (got !== 1'b1 || d !== want_d || n !== want_n)
            $display("FAIL %s: got strobe=%0b data=%h ceps=%0d, want data=%h ceps=%0d",
                     name, got, d, n, want_d, want_n);
        else pass_cnt++;
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        bit got; logic [7:0] d; int n;
        wait_rsp(cycles, got, d, n);
        chk_cnt++;
        if (got !== 1'b0) $display("FAIL %s: unexpected strobe data=%h after %0d ceps", name, d, n);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        _systemReset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_cnt++;
        if ({rsp_data, rsp_strobe, overflow, key_ready} !== {8'h00, 1'b0, 1'b0, 1'b1})
            $display("FAIL reset: got data=%h strb=%b ovf=%b rdy=%b, want 00 0 0 1",
                     rsp_data, rsp_strobe, overflow, key_ready);
        else pass_cnt++;
        @(posedge clk); #1;
        _systemReset = 1'b1;
    endtask

    task automatic test_model();
        int s0;
        send_cmd(8'h16);
        expect_rsp("model", 8'h0B, 16);
        @(posedge clk); #1;
        s0 = strobe_total;
        expect_quiet("model_single", 200);
        chk_cnt++;
        if (strobe_total !== s0) $display("FAIL model_count: got %0d strobes, want %0d", strobe_total, s0);
        else pass_cnt++;
        chk_cnt++;
        if (rsp_data !== 8'h0B) $display("FAIL model_hold: got %h want 0b", rsp_data);
        else pass_cnt++;
    endtask

    task automatic test_inquiry_key();
        push_key(8'h31);
        send_cmd(8'h10);
        expect_rsp("inq_key", 8'h31, 17);
        send_cmd(8'h14);
        expect_rsp("inq_key_empty_after", 8'h7B, 16);
    endtask

    task automatic test_inquiry_timeout();
        send_cmd(8'h10);
        expect_rsp("inq_timeout", 8'h7B, 116);
        send_cmd(8'h14);
        expect_rsp("instant_empty", 8'h7B, 16);
    endtask

    task automatic test_fifo_full();
        for (int i = 1; i <= 8; i++) push_key(8'(i));
        @(negedge clk);
        chk_cnt++;
        if (key_ready !== 1'b0 || overflow !== 1'b0)
            $display("FAIL full8: got rdy=%b ovf=%b, want 0 0", key_ready, overflow);
        else pass_cnt++;
        push_key(8'h09);
        @(negedge clk);
        chk_cnt++;
        if (key_ready !== 1'b0 || overflow !== 1'b1)
            $display("FAIL overflow: got rdy=%b ovf=%b, want 0 1", key_ready, overflow);
        else pass_cnt++;
        for (int i = 1; i <= 8; i++) begin
            send_cmd(8'h14);
            expect_rsp($sformatf("drain%0d", i), 8'(i), 16);
        end
        send_cmd(8'h14);
        expect_rsp("drain_empty", 8'h7B, 16);
    endtask

    task automatic test_cmds();
        int s0;
        send_cmd(8'h36);
        expect_rsp("test_ack", 8'h7D, 16);
        send_cmd(8'h55);
        expect_quiet("unknown", 820);
        send_cmd(8'h10);
        repeat (40) @(posedge clk);
        send_cmd(8'h16);
        expect_rsp("abort_model", 8'h0B, 16);
        @(posedge clk); #1;
        s0 = strobe_total;
        expect_quiet("abort_no_inq", 600);
        chk_cnt++;
        if (strobe_total !== s0) $display("FAIL abort_count: got %0d strobes, want %0d", strobe_total, s0);
        else pass_cnt++;
    endtask

    task automatic test_same_cycle();
        @(posedge clk); #1;
        cmd_data = 8'h14; cmd_strobe = 1'b1;
        key_code = 8'h42; key_valid = 1'b1;
        @(posedge clk); #1;
        cmd_strobe = 1'b0; key_valid = 1'b0;
        expect_rsp("same_cycle_null", 8'h7B, 16);
        send_cmd(8'h14);
        expect_rsp("same_cycle_key", 8'h42, 16);
    endtask

    task automatic test_reset_mid();
        push_key(8'h21); push_key(8'h22); push_key(8'h23);
        send_cmd(8'h16);
        repeat (10) @(posedge clk);
        #1 _systemReset = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if ({rsp_strobe, overflow, key_ready, rsp_data} !== {1'b0, 1'b0, 1'b1, 8'h00})
            $display("FAIL reset_mid: got strb=%b ovf=%b rdy=%b data=%h, want 0 0 1 00",
                     rsp_strobe, overflow, key_ready, rsp_data);
        else pass_cnt++;
        repeat (3) @(posedge clk);
        #1 _systemReset = 1'b1;
        expect_quiet("reset_mid_quiet", 200);
        send_cmd(8'h14);
        expect_rsp("reset_mid_instant", 8'h7B, 16);
    endtask

    initial begin
        test_reset();
        test_model();
        test_inquiry_key();
        test_inquiry_timeout();
        test_fifo_full();
        test_cmds();
        test_same_cycle();
        test_reset_mid();
        chk_cnt++;
        if (bad_strobe !== 0) $display("FAIL strobe_on_cep: got %0d strobes off cep, want 0", bad_strobe);
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
